// File: rtl/ac_arb_mux.sv
// N-channel arbitrated selector feeding the SMAC accumulator register.
// Fixed-priority, round-robin or forced grant into one bubble-free output stage.
module ac_arb_mux #(
  parameter  int M  = 16,
  parameter  int Pa = 8,
  parameter  int N  = 4,
  localparam int W  = $clog2(M) + Pa + 1,
  localparam int S  = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic           force_en,
  input  logic [S-1:0]   force_sel,
  output logic [W-1:0]   out_data,
  output logic [S-1:0]   out_ch,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [W-1:0] data_q, data_d;
  logic [S-1:0] ch_q, ch_d;
  logic         valid_q, valid_d;
  logic [S-1:0] ptr_q, ptr_d;

  logic [N-1:0] grant_s;
  logic         any_grant_s;
  logic [S-1:0] gnt_idx_s;
  logic [W-1:0] gnt_data_s;
  logic         load_s;

  assign load_s = !valid_q || out_ready;

  // Grant selection; round-robin scans ptr..N-1 first, then 0..ptr-1.
  always_comb begin
    grant_s     = '0;
    any_grant_s = 1'b0;
    gnt_idx_s   = '0;
    gnt_data_s  = '0;
    if (force_en) begin
      for (int i = 0; i < N; i++) begin
        if ((S'(i) == force_sel) && in_valid[i]) begin
          grant_s[i]  = 1'b1;
          any_grant_s = 1'b1;
          gnt_idx_s   = S'(i);
          gnt_data_s  = in_data[i*W +: W];
        end else begin
          grant_s[i] = 1'b0;
        end
      end
    end else if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (!any_grant_s && in_valid[i]) begin
          grant_s[i]  = 1'b1;
          any_grant_s = 1'b1;
          gnt_idx_s   = S'(i);
          gnt_data_s  = in_data[i*W +: W];
        end else begin
          grant_s[i] = 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!any_grant_s && in_valid[i] && (S'(i) >= ptr_q)) begin
          grant_s[i]  = 1'b1;
          any_grant_s = 1'b1;
          gnt_idx_s   = S'(i);
          gnt_data_s  = in_data[i*W +: W];
        end else begin
          grant_s[i] = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!any_grant_s && in_valid[i] && (S'(i) < ptr_q)) begin
          grant_s[i]  = 1'b1;
          any_grant_s = 1'b1;
          gnt_idx_s   = S'(i);
          gnt_data_s  = in_data[i*W +: W];
        end else begin
          grant_s[i] = grant_s[i];
        end
      end
    end
  end

  // Reset gates ready so nothing is accepted while the register is being cleared.
  always_comb begin
    if (rst_n && load_s) begin
      in_ready = grant_s;
    end else begin
      in_ready = '0;
    end
  end

  // Output register and pointer next-state.
  always_comb begin
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load_s) begin
      if (any_grant_s) begin
        data_d  = gnt_data_s;
        ch_d    = gnt_idx_s;
        valid_d = 1'b1;
        if (mode && !force_en) begin
          if (int'(gnt_idx_s) == N - 1) begin
            ptr_d = '0;
          end else begin
            ptr_d = gnt_idx_s + S'(1);
          end
        end else begin
          ptr_d = ptr_q;
        end
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_ac_arb_mux.sv
// Scoreboard bench for ac_arb_mux: a reference model predicts grants and pushes
// expected words, which are popped and compared when the output register loads.
module tb_ac_arb_mux;
  localparam int M = 16;
  localparam int PA = 8;
  localparam int N = 4;
  localparam int W = 13;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic           mode = 1'b0;
  logic           force_en = 1'b0;
  logic [S-1:0]   force_sel = '0;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_ch;
  logic           out_valid;
  logic           out_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  logic           m_valid = 1'b0;
  logic [W-1:0]   m_data = '0;
  logic [S-1:0]   m_ch = '0;
  int             m_ptr = 0;
  logic [S+W-1:0] sb_q[$];

  ac_arb_mux #(.M(M), .Pa(PA), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .force_en(force_en), .force_sel(force_sel),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_ch(input int i, input logic [W-1:0] v);
    in_data[i*W +: W] = v;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = '0;
    m_ptr   = 0;
    sb_q.delete();
  endtask

  // One cycle: inputs already driven at the negedge; check ready, clock, check output.
  task automatic step();
    logic [N-1:0]   eg;
    logic           any;
    int             gi;
    logic           ld;
    logic [S+W-1:0] e;
    eg = '0; any = 1'b0; gi = 0;
    #1;
    if (force_en) begin
      if (int'(force_sel) < N && in_valid[force_sel]) begin
        any = 1'b1; gi = int'(force_sel);
      end
    end else if (!mode) begin
      for (int i = N - 1; i >= 0; i--) if (in_valid[i]) begin any = 1'b1; gi = i; end
    end else begin
      for (int k = N - 1; k >= 0; k--)
        if (in_valid[(m_ptr + k) % N]) begin any = 1'b1; gi = (m_ptr + k) % N; end
    end
    if (any) eg[gi] = 1'b1;
    ld = !m_valid || out_ready;
    check("in_ready", 32'(in_ready), ld ? 32'(eg) : 32'd0);
    if (ld && any) sb_q.push_back({S'(gi), in_data[gi*W +: W]});
    @(posedge clk);
    #1;
    if (ld) begin
      if (any) begin
        m_valid = 1'b1;
        m_data  = in_data[gi*W +: W];
        m_ch    = S'(gi);
        if (mode && !force_en) m_ptr = (gi + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_hold", 32'(out_data), 32'(m_data));
    if (ld && any) begin
      if (sb_q.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_data", 32'(out_data), 32'(e[W-1:0]));
        check("sb_ch", 32'(out_ch), 32'(e[S+W-1:W]));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_ch(i, W'(13'h100 + i));
    in_valid = 4'b1111;
    mode = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ch", 32'(out_ch), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Round-robin from reset: 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_seq", 32'(out_ch), 32'(k % N));
    end
    in_valid = 4'b0001;
    step();
    in_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_1001", 32'(out_ch), (k % 2 == 0) ? 32'd3 : 32'd0);
    end

    // Fixed priority
    mode = 1'b0;
    set_ch(1, 13'h011);
    set_ch(3, 13'h033);
    in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      step();
      check("fp_data", 32'(out_data), 32'h011);
      check("fp_ch", 32'(out_ch), 32'd1);
    end

    // Back-pressure
    set_ch(0, 13'h1AB);
    set_ch(2, 13'h022);
    in_valid = 4'b0001;
    step();
    out_ready = 1'b0;
    in_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold", 32'(out_data), 32'h1AB);
    end
    out_ready = 1'b1;
    step();
    check("bp_next", 32'(out_data), 32'h022);
    check("bp_valid", 32'(out_valid), 32'd1);

    // Forced select; ptr is 1 here and must survive the forced period
    mode = 1'b1;
    force_en = 1'b1;
    force_sel = 2'd2;
    in_valid = 4'b0011;
    step();
    check("frc_none", 32'(out_valid), 32'd0);
    in_valid = 4'b0111;
    step();
    check("frc_ch2", 32'(out_ch), 32'd2);
    force_en = 1'b0;
    in_valid = 4'b1111;
    step();
    check("frc_ptr", 32'(out_ch), 32'd1);

    // Async reset mid-cycle with ptr=2
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
    check("arst_first", 32'(out_ch), 32'd0);

    // Random traffic through the scoreboard
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++) set_ch(i, W'($urandom_range(0, 8191)));
      in_valid  = N'($urandom_range(0, 15));
      mode      = 1'($urandom_range(0, 1));
      force_en  = ($urandom_range(0, 5) == 0);
      force_sel = S'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
